// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap unit: csrrw/csrrs/csrrc read-modify-write,
// illegal-access detection, trap/mret mstatus stacking, 64-bit counters and
// vectored interrupt redirect for the NPC core PC-redirect path.
module csr_trap_unit #(
   parameter int unsigned      XLEN          = 32,
   parameter logic [31:0]      MVENDORID_VAL = 32'h79737978,
   parameter logic [31:0]      MARCHID_VAL   = 32'h00bc614e,
   parameter logic [XLEN-1:0]  MTVEC_RESET   = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_csr_op,
   input  logic [11:0]      i_csr_addr,
   input  logic [XLEN-1:0]  i_csr_wsrc,
   output logic [XLEN-1:0]  o_csr_rdata,
   output logic             o_csr_illegal,
   input  logic             i_retire,
   input  logic             i_trap,
   input  logic [XLEN-1:0]  i_trap_cause,
   input  logic [XLEN-1:0]  i_trap_pc,
   input  logic [XLEN-1:0]  i_trap_tval,
   input  logic             i_mret,
   input  logic             i_irq_sw,
   input  logic             i_irq_timer,
   input  logic             i_irq_ext,
   output logic             o_irq_pending,
   output logic [XLEN-1:0]  o_irq_cause,
   output logic             o_redirect,
   output logic [XLEN-1:0]  o_redirect_pc
);

   typedef enum logic [1:0] {
      CSR_NONE = 2'b00,
      CSR_RW   = 2'b01,
      CSR_RS   = 2'b10,
      CSR_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

   localparam bit              IS32       = (XLEN == 32);
   localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(12'h888);
   localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);

   // architectural state
   logic             mstatus_mie_q;
   logic             mstatus_mpie_q;
   logic [XLEN-1:0]  mie_q;
   logic [XLEN-1:0]  mtvec_q;
   logic [XLEN-1:0]  mscratch_q;
   logic [XLEN-1:0]  mepc_q;
   logic [XLEN-1:0]  mcause_q;
   logic [XLEN-1:0]  mtval_q;
   logic [63:0]      mcycle_q;
   logic [63:0]      minstret_q;

   // combinational helpers
   csr_op_e          op;
   logic [XLEN-1:0]  mip;
   logic [XLEN-1:0]  mstatus_rd;
   logic [XLEN-1:0]  csr_old;
   logic             csr_valid;
   logic             wr_req;
   logic             wr_en;
   logic [XLEN-1:0]  wval;
   logic [63:0]      wval64;
   logic [63:0]      mcycle_nxt;
   logic [63:0]      minstret_nxt;
   logic [XLEN-1:0]  irq_hits;
   logic [XLEN-1:0]  trap_base;
   logic [XLEN-1:0]  trap_tgt;

   assign op         = csr_op_e'(i_csr_op);
   assign mstatus_rd = XLEN'({2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});

   // interrupt lines map straight onto mip; no register in between
   always_comb begin
      // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
      mip     = '0;
      mip[3]  = i_irq_sw;
      mip[7]  = i_irq_timer;
      mip[11] = i_irq_ext;
   end

   // address decode and current-value read mux
   always_comb begin
      csr_valid = 1'b1;
      csr_old   = '0;
      unique case (i_csr_addr)
         ADDR_MSTATUS:   csr_old = mstatus_rd;
         ADDR_MIE:       csr_old = mie_q;
         ADDR_MTVEC:     csr_old = mtvec_q;
         ADDR_MSCRATCH:  csr_old = mscratch_q;
         ADDR_MEPC:      csr_old = mepc_q;
         ADDR_MCAUSE:    csr_old = mcause_q;
         ADDR_MTVAL:     csr_old = mtval_q;
         ADDR_MIP:       csr_old = mip;
         ADDR_MCYCLE:    csr_old = mcycle_q[XLEN-1:0];
         ADDR_MINSTRET:  csr_old = minstret_q[XLEN-1:0];
         ADDR_MCYCLEH: begin
            if (IS32) csr_old = XLEN'(mcycle_q[63:32]);
            else      csr_valid = 1'b0;
         end
         ADDR_MINSTRETH: begin
            if (IS32) csr_old = XLEN'(minstret_q[63:32]);
            else      csr_valid = 1'b0;
         end
         ADDR_MVENDORID: csr_old = XLEN'(MVENDORID_VAL);
         ADDR_MARCHID:   csr_old = XLEN'(MARCHID_VAL);
         default:        csr_valid = 1'b0;
      endcase
   end

   // read-modify-write value, legality and the final write enable
   always_comb begin
      wr_req = (op == CSR_RW) || (((op == CSR_RS) || (op == CSR_RC)) && (i_csr_wsrc != '0));
      o_csr_illegal = (op != CSR_NONE) &&
                      (!csr_valid || (wr_req && (i_csr_addr[11:10] == 2'b11)));
      o_csr_rdata = ((op != CSR_NONE) && !o_csr_illegal) ? csr_old : '0;
      // trap and mret own this cycle's state update
      wr_en = wr_req && !o_csr_illegal && !i_trap && !i_mret;
      unique case (op)
         CSR_RS:  wval = csr_old | i_csr_wsrc;
         CSR_RC:  wval = csr_old & ~i_csr_wsrc;
         default: wval = i_csr_wsrc;
      endcase
      wval64 = 64'(wval);
   end

   // counter next values; a write replaces its half, the other half keeps counting
   always_comb begin
      mcycle_nxt   = mcycle_q + 64'd1;
      minstret_nxt = (i_retire && !i_trap) ? minstret_q + 64'd1 : minstret_q;
      if (wr_en) begin
         unique case (i_csr_addr)
            ADDR_MCYCLE:    mcycle_nxt   = IS32 ? {mcycle_nxt[63:32], wval64[31:0]} : wval64;
            ADDR_MCYCLEH:   mcycle_nxt   = {wval64[31:0], mcycle_nxt[31:0]};
            ADDR_MINSTRET:  minstret_nxt = IS32 ? {minstret_nxt[63:32], wval64[31:0]} : wval64;
            ADDR_MINSTRETH: minstret_nxt = {wval64[31:0], minstret_nxt[31:0]};
            default: ;
         endcase
      end
   end

   // interrupt arbitration and redirect target; trap outranks mret
   always_comb begin
      irq_hits      = mip & mie_q;
      o_irq_pending = mstatus_mie_q && (irq_hits != '0);
      o_irq_cause   = '0;
      if (o_irq_pending) begin
         o_irq_cause[XLEN-1] = 1'b1;
         if (irq_hits[11])     o_irq_cause[3:0] = 4'd11;
         else if (irq_hits[7]) o_irq_cause[3:0] = 4'd7;
         else                  o_irq_cause[3:0] = 4'd3;
      end
      trap_base = {mtvec_q[XLEN-1:2], 2'b00};
      trap_tgt  = trap_base;
      if (mtvec_q[0] && i_trap_cause[XLEN-1])
         trap_tgt = trap_base + {i_trap_cause[XLEN-3:0], 2'b00};
      o_redirect    = i_trap || i_mret;
      o_redirect_pc = i_trap ? trap_tgt : (i_mret ? mepc_q : '0);
   end

   // state update: reset, then trap > mret > CSR write; counters always advance
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= MTVEC_RESET & MTVEC_MASK;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         mcycle_q   <= mcycle_nxt;
         minstret_q <= minstret_nxt;
         if (i_trap) begin
            mepc_q         <= {i_trap_pc[XLEN-1:2], 2'b00};
            mcause_q       <= i_trap_cause;
            mtval_q        <= i_trap_tval;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
         end else if (i_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end else if (wr_en) begin
            unique case (i_csr_addr)
               ADDR_MSTATUS: begin
                  mstatus_mie_q  <= wval[3];
                  mstatus_mpie_q <= wval[7];
               end
               ADDR_MIE:      mie_q      <= wval & MIE_MASK;
               ADDR_MTVEC:    mtvec_q    <= wval & MTVEC_MASK;
               ADDR_MSCRATCH: mscratch_q <= wval;
               ADDR_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
               ADDR_MCAUSE:   mcause_q   <= wval;
               ADDR_MTVAL:    mtval_q    <= wval;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit at XLEN=32 with hand-computed expectations.
module tb_csr_trap_unit;

   localparam int XLEN = 32;
   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       csr_op;
   logic [11:0]      csr_addr;
   logic [XLEN-1:0]  csr_wsrc;
   logic [XLEN-1:0]  csr_rdata;
   logic             csr_illegal;
   logic             retire;
   logic             trap;
   logic [XLEN-1:0]  trap_cause;
   logic [XLEN-1:0]  trap_pc;
   logic [XLEN-1:0]  trap_tval;
   logic             mret;
   logic             irq_sw;
   logic             irq_timer;
   logic             irq_ext;
   logic             irq_pending;
   logic [XLEN-1:0]  irq_cause;
   logic             redirect;
   logic [XLEN-1:0]  redirect_pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   csr_trap_unit dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_csr_op      (csr_op),
      .i_csr_addr    (csr_addr),
      .i_csr_wsrc    (csr_wsrc),
      .o_csr_rdata   (csr_rdata),
      .o_csr_illegal (csr_illegal),
      .i_retire      (retire),
      .i_trap        (trap),
      .i_trap_cause  (trap_cause),
      .i_trap_pc     (trap_pc),
      .i_trap_tval   (trap_tval),
      .i_mret        (mret),
      .i_irq_sw      (irq_sw),
      .i_irq_timer   (irq_timer),
      .i_irq_ext     (irq_ext),
      .o_irq_pending (irq_pending),
      .o_irq_cause   (irq_cause),
      .o_redirect    (redirect),
      .o_redirect_pc (redirect_pc)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   // move to the next negedge and drop all one-cycle controls
   task automatic cyc();
      @(negedge clk);
      csr_op = OP_NONE;
      csr_wsrc = '0;
      trap = 1'b0;
      mret = 1'b0;
      retire = 1'b0;
   endtask

   task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [XLEN-1:0] val);
      cyc();
      csr_op = op;
      csr_addr = addr;
      csr_wsrc = val;
      #1;
   endtask

   task automatic chk_rd(input string tag, input logic [11:0] addr, input logic [XLEN-1:0] exp);
      wr(OP_RS, addr, '0);
      check(tag, csr_rdata, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      csr_op = OP_NONE; csr_addr = '0; csr_wsrc = '0;
      retire = 1'b0; trap = 1'b0; mret = 1'b0;
      trap_cause = '0; trap_pc = '0; trap_tval = '0;
      irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      repeat (3) cyc();

      // first cycle after reset release
      cyc();
      rst_n = 1'b1;
      csr_op = OP_RS; csr_addr = 12'hB00;
      #1;
      check("rst_mcycle", csr_rdata, 0);
      check("rst_illegal", csr_illegal, 0);
      check("rst_pending", irq_pending, 0);
      check("rst_redirect", redirect, 0);
      chk_rd("rst_minstret", 12'hB02, 0);
      chk_rd("rst_mstatus", 12'h300, 32'h0000_1800);
      chk_rd("mvendorid", 12'hF11, 32'h7973_7978);
      chk_rd("marchid", 12'hF12, 32'h00bc_614e);
      wr(OP_RS, 12'h7C0, '0);
      check("bad_addr_illegal", csr_illegal, 1);
      check("bad_addr_rdata", csr_rdata, 0);
      wr(OP_RS, 12'hC00, '0);
      check("c00_illegal", csr_illegal, 1);

      // mtvec bit1 hardwired, mie mask
      wr(OP_RW, 12'h305, 32'h8000_0003);
      chk_rd("mtvec_bit1", 12'h305, 32'h8000_0001);
      wr(OP_RW, 12'h304, 32'hFFFF_FFFF);
      chk_rd("mie_mask", 12'h304, 32'h0000_0888);
      wr(OP_RW, 12'h304, 32'h0000_0800);
      wr(OP_RS, 12'h300, 32'h8);
      chk_rd("mstatus_mie_set", 12'h300, 32'h0000_1808);

      // external interrupt and vectored trap
      cyc();
      irq_ext = 1'b1;
      #1;
      check("ext_pending", irq_pending, 1);
      check("ext_cause", irq_cause, 32'h8000_000B);
      cyc();
      trap = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h8000_0040; trap_tval = 32'h123;
      #1;
      check("trap_redirect", redirect, 1);
      check("trap_vec_pc", redirect_pc, 32'h8000_002C);
      cyc();
      irq_ext = 1'b0;
      csr_op = OP_RS; csr_addr = 12'h300;
      #1;
      check("trap_mstatus", csr_rdata, 32'h0000_1880);
      check("trap_no_pending", irq_pending, 0);
      chk_rd("trap_mepc", 12'h341, 32'h8000_0040);
      chk_rd("trap_mcause", 12'h342, 32'h8000_000B);
      chk_rd("trap_mtval", 12'h343, 32'h0000_0123);

      // mret
      wr(OP_RW, 12'h341, 32'h8000_0106);
      chk_rd("mepc_align", 12'h341, 32'h8000_0104);
      cyc();
      mret = 1'b1;
      #1;
      check("mret_redirect", redirect, 1);
      check("mret_pc", redirect_pc, 32'h8000_0104);
      chk_rd("mret_mstatus", 12'h300, 32'h0000_1888);

      // no-write set, read-only write, clear
      wr(OP_RS, 12'h300, '0);
      check("rs0_illegal", csr_illegal, 0);
      check("rs0_rdata", csr_rdata, 32'h0000_1888);
      wr(OP_RW, 12'hF11, '0);
      check("ro_write_illegal", csr_illegal, 1);
      check("ro_write_rdata", csr_rdata, 0);
      chk_rd("ro_unchanged", 12'hF11, 32'h7973_7978);
      wr(OP_RC, 12'h300, 32'h8);
      chk_rd("rc_mstatus", 12'h300, 32'h0000_1880);

      // mip follows lines, writes ignored and legal
      cyc();
      irq_sw = 1'b1; irq_timer = 1'b1;
      csr_op = OP_RS; csr_addr = 12'h344;
      #1;
      check("mip_read", csr_rdata, 32'h0000_0088);
      wr(OP_RW, 12'h344, 32'hFFFF_FFFF);
      check("mip_write_legal", csr_illegal, 0);
      chk_rd("mip_unchanged", 12'h344, 32'h0000_0088);

      // interrupt priority
      wr(OP_RW, 12'h304, 32'h0000_0888);
      wr(OP_RS, 12'h300, 32'h8);
      cyc();
      #1;
      check("prio_timer", irq_cause, 32'h8000_0007);
      cyc();
      irq_ext = 1'b1;
      #1;
      check("prio_ext", irq_cause, 32'h8000_000B);
      cyc();
      irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
      #1;
      check("irq_clear", irq_pending, 0);

      // mcycle halves: carry from low into high
      wr(OP_RW, 12'hB80, 32'h5);
      wr(OP_RW, 12'hB00, 32'hFFFF_FFFF);
      chk_rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
      chk_rd("mcycle_wrapped_lo", 12'hB00, 32'h0);
      chk_rd("mcycleh_carry", 12'hB80, 32'h6);
      // full 64-bit wrap
      wr(OP_RW, 12'hB80, 32'hFFFF_FFFF);
      wr(OP_RW, 12'hB00, 32'hFFFF_FFFF);
      chk_rd("mcycle_max_lo", 12'hB00, 32'hFFFF_FFFF);
      chk_rd("mcycle_wrap_hi", 12'hB80, 32'h0);

      // minstret: write overrides increment, trap blocks increment
      cyc();
      retire = 1'b1;
      csr_op = OP_RW; csr_addr = 12'hB02; csr_wsrc = 32'h100;
      #1;
      chk_rd("minstret_written", 12'hB02, 32'h100);
      cyc();
      retire = 1'b1;
      #1;
      chk_rd("minstret_inc", 12'hB02, 32'h101);
      cyc();
      retire = 1'b1; trap = 1'b1; mret = 1'b1;
      trap_cause = 32'h2; trap_pc = 32'h0000_0300;
      #1;
      check("trap_over_mret_pc", redirect_pc, 32'h8000_0000);
      chk_rd("minstret_trap_hold", 12'hB02, 32'h101);
      chk_rd("trap_over_mret_mepc", 12'h341, 32'h0000_0300);

      // trap beats same-cycle CSR write
      cyc();
      csr_op = OP_RW; csr_addr = 12'h341; csr_wsrc = 32'h1234;
      trap = 1'b1; trap_cause = 32'h2; trap_pc = 32'h8000_0200;
      #1;
      chk_rd("trap_over_write", 12'h341, 32'h8000_0200);

      // reset mid-sequence
      wr(OP_RW, 12'h340, 32'hDEAD_BEEF);
      chk_rd("mscratch", 12'h340, 32'hDEAD_BEEF);
      cyc();
      rst_n = 1'b0;
      trap = 1'b1; trap_cause = 32'h8000_0003; trap_pc = 32'h44;
      #1;
      cyc();
      rst_n = 1'b1;
      csr_op = OP_RS; csr_addr = 12'hB00;
      #1;
      check("rst2_mcycle", csr_rdata, 0);
      check("rst2_redirect", redirect, 0);
      chk_rd("rst2_mstatus", 12'h300, 32'h0000_1800);
      chk_rd("rst2_mscratch", 12'h340, 0);
      chk_rd("rst2_mepc", 12'h341, 0);
      chk_rd("rst2_mcause", 12'h342, 0);
      chk_rd("rst2_mtval", 12'h343, 0);
      chk_rd("rst2_mie", 12'h304, 0);
      chk_rd("rst2_mtvec", 12'h305, 0);
      chk_rd("rst2_minstret", 12'hB02, 0);

      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
